// File: rtl/inst_mem_loader.sv
// -----------------------------------------------------------------------------
// inst_mem_loader
//
// Writer side of the instruction-memory load port. A program arrives as a byte
// stream from the UART receiver; bytes are packed little-endian into 32-bit
// instruction words and written to consecutive word addresses. The CPU is held
// until the HALT word (which is itself stored) has been written.
//
// Ports:
//   i_clk             clock, rising edge
//   i_rst             asynchronous reset, active-low
//   i_start           one-cycle pulse, starts a load session (ignored while busy)
//   i_rx_data         byte from the UART receiver
//   i_rx_valid        one-cycle pulse, i_rx_data valid this cycle
//   o_inst_mem_wr_en  instruction memory write strobe (single cycle)
//   o_inst_mem_addr   byte address of the write, always word aligned
//   o_inst_mem_data   instruction word to write
//   o_cpu_hold        keeps PC and pipeline stalled (low only once done)
//   o_busy            session in progress
//   o_done            sticky, HALT word stored
//   o_error           sticky, overflow or inter-byte timeout
//   o_word_count      words written in the current session (saturates)
// -----------------------------------------------------------------------------
module inst_mem_loader #(
    parameter int               NBITS          = 32,
    parameter int               MEM_DEPTH      = 256,
    parameter logic [NBITS-1:0] HALT_WORD      = 32'hFFFF_FFFF,
    parameter int               TIMEOUT_CYCLES = 1_000_000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_valid,
    output logic             o_inst_mem_wr_en,
    output logic [NBITS-1:0] o_inst_mem_addr,
    output logic [NBITS-1:0] o_inst_mem_data,
    output logic             o_cpu_hold,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error,
    output logic [NBITS-1:0] o_word_count
);

    // The timeout counter only has to reach TIMEOUT_CYCLES-1: the idle cycle
    // seen while it holds that value is the one that expires the word.
    localparam int               TMO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [NBITS-1:0] LAST_IDX = NBITS'(MEM_DEPTH - 1);
    localparam logic [NBITS-1:0] DEPTH_N  = NBITS'(MEM_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic               tmo_hit_s;
    logic [1:0]         idx_r;
    logic [NBITS-1:0]   word_r;
    logic [NBITS-1:0]   cnt_r;
    logic [TMO_W-1:0]   tmo_r;
    logic               wr_en_r;
    logic [NBITS-1:0]   addr_r;
    logic [NBITS-1:0]   data_r;
    logic               hold_r;
    logic               busy_r;
    logic               done_r;
    logic               error_r;

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; the timeout only runs while a word is partially received
    always_comb begin
        state_s   = state_r;
        tmo_hit_s = 1'b0;
        if ((state_r == ST_RECV) && !i_rx_valid && (idx_r != 2'd0) && (tmo_r == TMO_LAST)) begin
            tmo_hit_s = 1'b1;
        end else begin
            tmo_hit_s = 1'b0;
        end
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (i_start) begin
                    state_s = ST_RECV;
                end else begin
                    state_s = state_r;
                end
            end
            ST_RECV: begin
                if (i_rx_valid && (idx_r == 2'd3)) begin
                    state_s = ST_WRITE;
                end else if (tmo_hit_s) begin
                    state_s = ST_ERROR;
                end else begin
                    state_s = ST_RECV;
                end
            end
            ST_WRITE: begin
                // HALT wins over overflow: a HALT in the last slot is a clean finish
                if (data_r == HALT_WORD) begin
                    state_s = ST_DONE;
                end else if (cnt_r == LAST_IDX) begin
                    state_s = ST_ERROR;
                end else begin
                    state_s = ST_RECV;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Byte assembly, counters and registered status/write outputs
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            idx_r   <= 2'd0;
            word_r  <= '0;
            cnt_r   <= '0;
            tmo_r   <= '0;
            wr_en_r <= 1'b0;
            addr_r  <= '0;
            data_r  <= '0;
            hold_r  <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            error_r <= 1'b0;
        end else begin
            // WRITE is only ever entered from RECV and always left after one
            // cycle, so the strobe can never be two cycles long.
            wr_en_r <= (state_s == ST_WRITE);
            hold_r  <= (state_s != ST_DONE);
            busy_r  <= (state_s == ST_RECV) || (state_s == ST_WRITE);
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (i_start) begin
                        idx_r   <= 2'd0;
                        cnt_r   <= '0;
                        tmo_r   <= '0;
                        done_r  <= 1'b0;
                        error_r <= 1'b0;
                    end
                end
                ST_RECV: begin
                    if (i_rx_valid) begin
                        word_r[{idx_r, 3'b000} +: 8] <= i_rx_data;
                        idx_r <= idx_r + 2'd1;
                        tmo_r <= '0;
                        if (idx_r == 2'd3) begin
                            // Capture the full word straight from the bus so the
                            // strobe lands one cycle after the last byte.
                            addr_r <= {cnt_r[NBITS-3:0], 2'b00};
                            data_r <= NBITS'({i_rx_data, word_r[23:0]});
                        end
                    end else if (tmo_hit_s) begin
                        error_r <= 1'b1;
                    end else if (idx_r != 2'd0) begin
                        tmo_r <= tmo_r + TMO_W'(1);
                    end
                end
                ST_WRITE: begin
                    cnt_r   <= (cnt_r < DEPTH_N) ? (cnt_r + NBITS'(1)) : cnt_r;
                    tmo_r   <= '0;
                    done_r  <= (state_s == ST_DONE);
                    error_r <= (state_s == ST_ERROR);
                    // A byte arriving during the write starts the next word
                    if (i_rx_valid) begin
                        word_r[7:0] <= i_rx_data;
                        idx_r       <= 2'd1;
                    end
                end
                default: begin
                    idx_r <= 2'd0;
                end
            endcase
        end
    end

    assign o_inst_mem_wr_en = wr_en_r;
    assign o_inst_mem_addr  = addr_r;
    assign o_inst_mem_data  = data_r;
    assign o_cpu_hold       = hold_r;
    assign o_busy           = busy_r;
    assign o_done           = done_r;
    assign o_error          = error_r;
    assign o_word_count     = cnt_r;

endmodule

// File: tb/tb_inst_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_inst_mem_loader
//
// Self-checking bench for inst_mem_loader with a small memory (4 words) and a
// short inter-byte timeout (16 cycles). Directed word tables, hand sequences
// for the multi-cycle corners, and randomized sessions checked against a
// word-level reference model.
// -----------------------------------------------------------------------------
module tb_inst_mem_loader;

    localparam int          DEPTH = 4;
    localparam int          TMO   = 16;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] data;
    logic        hold;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] wcnt;

    int checks = 0;
    int errors = 0;

    inst_mem_loader #(
        .NBITS(32), .MEM_DEPTH(DEPTH), .HALT_WORD(HALT), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_rx_data(rx_data),
        .i_rx_valid(rx_valid), .o_inst_mem_wr_en(wr_en), .o_inst_mem_addr(addr),
        .o_inst_mem_data(data), .o_cpu_hold(hold), .o_busy(busy), .o_done(done),
        .o_error(err), .o_word_count(wcnt)
    );

    always #5 clk = ~clk;

    // Write log, sampled mid-cycle
    logic [31:0] log_addr [0:1023];
    logic [31:0] log_data [0:1023];
    int          wr_total = 0;
    int          viol_cnt = 0;
    logic        prev_wr  = 1'b0;

    always @(negedge clk) begin
        if (wr_en) begin
            if (wr_total < 1024) begin
                log_addr[wr_total] <= addr;
                log_data[wr_total] <= data;
            end
            wr_total <= wr_total + 1;
            if (prev_wr || (addr >= 32'(4 * DEPTH))) viol_cnt <= viol_cnt + 1;
        end
        prev_wr <= wr_en;
    end

    // Expected writes of the current session
    logic [31:0] exp_addr_a [0:7];
    logic [31:0] exp_data_a [0:7];
    int          exp_n;

    typedef struct {
        logic [31:0] seq;       // bytes in send order, first byte in [31:24]
        int          gap;       // idle cycles between bytes of the word
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] seq, input int gap);
        for (int k = 0; k < 4; k++) begin
            send_byte(seq[31 - 8*k -: 8]);
            if (k < 3) idle(gap);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        idle(1);
    endtask

    // Reference: word value as received little-endian from a send-order sequence
    function automatic logic [31:0] le_word(input logic [31:0] seq);
        return {seq[7:0], seq[15:8], seq[23:16], seq[31:24]};
    endfunction

    task automatic check_log(input string name, input int base);
        check({name, "_nwr"}, 64'(wr_total - base), 64'(exp_n));
        for (int i = 0; i < exp_n && i < wr_total - base; i++) begin
            check({name, "_addr"}, 64'(log_addr[base + i]), 64'(exp_addr_a[i]));
            check({name, "_data"}, 64'(log_data[base + i]), 64'(exp_data_a[i]));
        end
    endtask

    task automatic check_status(input string name, input logic e_done, input logic e_err,
                                input logic e_busy, input logic e_hold, input int e_cnt);
        check({name, "_done"}, 64'(done), 64'(e_done));
        check({name, "_error"}, 64'(err), 64'(e_err));
        check({name, "_busy"}, 64'(busy), 64'(e_busy));
        check({name, "_hold"}, 64'(hold), 64'(e_hold));
        check({name, "_wcnt"}, 64'(wcnt), 64'(e_cnt));
    endtask

    initial begin
        vec_t        vec_a [0:5];
        int          base;
        logic [7:0]  rb [0:23];
        int          rg [0:23];
        int          nwords;
        int          nb;
        logic [31:0] w;
        logic        e_done;
        logic        e_err;
        logic        stop;

        vec_a[0] = '{seq: 32'h1300_0020, gap: 2, exp_addr: 32'h0, exp_data: 32'h2000_0013};
        vec_a[1] = '{seq: 32'hFFFF_FFFF, gap: 1, exp_addr: 32'h4, exp_data: 32'hFFFF_FFFF};
        vec_a[2] = '{seq: 32'h0102_0304, gap: 0, exp_addr: 32'h0, exp_data: 32'h0403_0201};
        vec_a[3] = '{seq: 32'hA0B1_C2D3, gap: 0, exp_addr: 32'h4, exp_data: 32'hD3C2_B1A0};
        vec_a[4] = '{seq: 32'h5A6B_7C8D, gap: 0, exp_addr: 32'h8, exp_data: 32'h8D7C_6B5A};
        vec_a[5] = '{seq: 32'hFFFF_FFFF, gap: 0, exp_addr: 32'hC, exp_data: 32'hFFFF_FFFF};

        rst = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        @(posedge clk); #1;
        do_reset();

        // Reset state, bytes before start are ignored
        check("rst_wr_en", 64'(wr_en), 64'(0));
        check_status("rst", 1'b0, 1'b0, 1'b0, 1'b1, 0);
        base = wr_total;
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'h12); send_byte(8'h34);
        idle(3);
        exp_n = 0;
        check_log("idle_rx", base);
        check("idle_rx_busy", 64'(busy), 64'(0));

        // Two-word program, exact strobe and done latency
        base = wr_total;
        pulse_start();
        send_word(vec_a[0].seq, vec_a[0].gap);
        idle(1);
        send_word(vec_a[1].seq, vec_a[1].gap);
        check("halt_strobe", 64'(wr_en), 64'(1));
        check("halt_done_early", 64'(done), 64'(0));
        check("halt_hold_early", 64'(hold), 64'(1));
        @(posedge clk); #1;
        check("halt_strobe_end", 64'(wr_en), 64'(0));
        check("halt_done", 64'(done), 64'(1));
        check("halt_hold", 64'(hold), 64'(0));
        exp_n = 2;
        for (int i = 0; i < 2; i++) begin
            exp_addr_a[i] = vec_a[i].exp_addr;
            exp_data_a[i] = vec_a[i].exp_data;
        end
        check_log("two_word", base);
        check_status("two_word", 1'b1, 1'b0, 1'b0, 1'b0, 2);

        // Back-to-back bytes, including during the write cycles
        base = wr_total;
        pulse_start();
        for (int i = 2; i < 6; i++) send_word(vec_a[i].seq, vec_a[i].gap);
        idle(3);
        exp_n = 4;
        for (int i = 0; i < 4; i++) begin
            exp_addr_a[i] = vec_a[i + 2].exp_addr;
            exp_data_a[i] = vec_a[i + 2].exp_data;
        end
        check_log("b2b", base);
        check_status("b2b", 1'b1, 1'b0, 1'b0, 1'b0, 4);

        // Overflow: five non-HALT words into a four-word memory
        base = wr_total;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            send_word(32'h1020_3040 + 32'(i), 1);
            idle(1);
        end
        idle(3);
        exp_n = 4;
        for (int i = 0; i < 4; i++) begin
            exp_addr_a[i] = 32'(4 * i);
            exp_data_a[i] = le_word(32'h1020_3040 + 32'(i));
        end
        check_log("ovf", base);
        check_status("ovf", 1'b0, 1'b1, 1'b0, 1'b1, 4);

        // Timeout after two bytes, then a fresh session from address 0
        base = wr_total;
        pulse_start();
        send_byte(8'h11); send_byte(8'h22);
        idle(TMO - 1);
        check("tmo_early_error", 64'(err), 64'(0));
        check("tmo_early_busy", 64'(busy), 64'(1));
        idle(1);
        exp_n = 0;
        check_log("tmo", base);
        check_status("tmo", 1'b0, 1'b1, 1'b0, 1'b1, 0);
        base = wr_total;
        pulse_start();
        check_status("tmo_restart", 1'b0, 1'b0, 1'b1, 1'b1, 0);
        send_word(32'hDDCC_BBAA, 1);
        idle(1);
        send_word(HALT, 0);
        idle(3);
        exp_n = 2;
        exp_addr_a[0] = 32'h0; exp_data_a[0] = 32'hAABB_CCDD;
        exp_addr_a[1] = 32'h4; exp_data_a[1] = 32'hFFFF_FFFF;
        check_log("tmo_new", base);
        check_status("tmo_new", 1'b1, 1'b0, 1'b0, 1'b0, 2);

        // Asynchronous reset in the middle of a word
        base = wr_total;
        pulse_start();
        send_word(32'h0102_0304, 0);
        idle(2);
        check("mid_rst_pre_cnt", 64'(wcnt), 64'(1));
        send_byte(8'h77); send_byte(8'h66);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_wr_en", 64'(wr_en), 64'(0));
        check_status("mid_rst", 1'b0, 1'b0, 1'b0, 1'b1, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        idle(1);
        send_byte(8'h55); send_byte(8'h44);
        idle(3);
        exp_n = 1;
        exp_addr_a[0] = 32'h0; exp_data_a[0] = 32'h0403_0201;
        check_log("mid_rst", base);
        check("mid_rst_busy_after", 64'(busy), 64'(0));

        // Start while busy is ignored: count and address keep advancing
        base = wr_total;
        pulse_start();
        send_word(32'h9988_7766, 1);
        idle(2);
        pulse_start();
        send_word(HALT, 1);
        idle(3);
        exp_n = 2;
        exp_addr_a[0] = 32'h0; exp_data_a[0] = 32'h6677_8899;
        exp_addr_a[1] = 32'h4; exp_data_a[1] = 32'hFFFF_FFFF;
        check_log("busy_start", base);
        check_status("busy_start", 1'b1, 1'b0, 1'b0, 1'b0, 2);

        // Randomized sessions against a word-level model
        for (int s = 0; s < 30; s++) begin
            nwords = $urandom_range(1, 6);
            nb = 4 * nwords;
            for (int wi = 0; wi < nwords; wi++) begin
                w = $urandom();
                if (w == HALT) w = 32'h0;
                if ((wi == nwords - 1) && ($urandom_range(0, 1) == 1)) w = HALT;
                for (int k = 0; k < 4; k++) rb[4*wi + k] = w[8*k +: 8];
            end
            for (int i = 0; i < nb; i++) begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 60)      rg[i] = $urandom_range(0, 3);
                else if (r < 90) rg[i] = $urandom_range(4, TMO - 2);
                else if (r < 95) rg[i] = TMO - 1;
                else             rg[i] = $urandom_range(TMO, TMO + 2);
            end

            // Model: words in order; a long gap inside a word, HALT, or a full
            // memory ends the session.
            exp_n = 0; e_done = 1'b0; e_err = 1'b0; stop = 1'b0;
            for (int wi = 0; wi < nwords && !stop; wi++) begin
                for (int k = 0; k < 3 && !stop; k++) begin
                    if (rg[4*wi + k] >= TMO) begin
                        e_err = 1'b1;
                        stop  = 1'b1;
                    end
                end
                if (!stop) begin
                    w = {rb[4*wi + 3], rb[4*wi + 2], rb[4*wi + 1], rb[4*wi]};
                    exp_addr_a[exp_n] = 32'(4 * wi);
                    exp_data_a[exp_n] = w;
                    exp_n++;
                    if (w == HALT) begin
                        e_done = 1'b1;
                        stop   = 1'b1;
                    end else if (exp_n == DEPTH) begin
                        e_err = 1'b1;
                        stop  = 1'b1;
                    end
                end
            end

            do_reset();
            base = wr_total;
            pulse_start();
            for (int i = 0; i < nb; i++) begin
                send_byte(rb[i]);
                if (i < nb - 1) idle(rg[i]);
            end
            idle(TMO + 4);
            check_log("rand", base);
            check_status("rand", e_done, e_err, !e_done && !e_err, !e_done, exp_n);
        end

        check("strobe_rules", 64'(viol_cnt), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Writer side of the instruction-memory load port used by the instruction fetch stage.
- Receives a program as a byte stream from the UART receiver.
- Assembles the bytes into 32-bit little-endian instruction words and writes them to consecutive word addresses of instruction memory.
- Holds the CPU pipeline until a HALT word has been stored, then releases it.

Parameters:
- NBITS, 32, instruction/data/address width.
- MEM_DEPTH, 256, instruction memory capacity in words.
- HALT_WORD, 32'hFFFF_FFFF, end-of-program instruction; it is itself written to memory.
- TIMEOUT_CYCLES, 1_000_000, maximum idle cycles allowed between bytes of a partially received word.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous reset, active-low.
- i_start  in  1  one-cycle pulse; starts a load session.
- i_rx_data  in  8  byte from the UART receiver.
- i_rx_valid  in  1  one-cycle pulse; i_rx_data is valid in that cycle.
- o_inst_mem_wr_en  out  1  instruction memory write strobe.
- o_inst_mem_addr  out  NBITS  byte address for the write; always a multiple of 4.
- o_inst_mem_data  out  NBITS  instruction word to write.
- o_cpu_hold  out  1  keeps the PC and pipeline stalled.
- o_busy  out  1  a session is in progress.
- o_done  out  1  sticky; HALT word has been stored.
- o_error  out  1  sticky; overflow or timeout occurred.
- o_word_count  out  NBITS  number of words written in the current session.

Behaviour:
- Reset (i_rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0 except o_cpu_hold=1.
  - Byte index, address, word count and timeout counter are cleared.
  - Reset asserted mid-session aborts the session; no further writes occur.
- States: IDLE, RECV, WRITE, DONE, ERROR.
- o_cpu_hold=1 in every state except DONE.
- o_busy=1 in RECV and WRITE only.
- IDLE / DONE / ERROR:
  - i_rx_valid is ignored.
  - i_start moves to RECV and clears byte index, address, o_word_count, o_done, o_error and the timeout counter.
- RECV:
  - Each i_rx_valid places i_rx_data into byte lane [8*idx+7:8*idx], then idx increments.
  - The first byte received goes to bits [7:0].
  - When the 4th byte arrives (idx=3), the next state is WRITE.
- WRITE (exactly 1 cycle):
  - o_inst_mem_wr_en=1, o_inst_mem_addr = 4*o_word_count, o_inst_mem_data = assembled word.
  - Latency: 4th byte accepted at edge N; the write strobe is high during cycle N+1.
  - Exiting WRITE: o_word_count increments and address advances by 4.
  - If the word equals HALT_WORD, go to DONE: o_done=1 and o_cpu_hold=0 from cycle N+2.
  - Otherwise return to RECV.
  - A byte with i_rx_valid during WRITE is accepted as byte 0 of the next word. No byte is ever dropped.
- Overflow:
  - A non-HALT word written at index MEM_DEPTH-1 leads to ERROR instead of RECV.
  - Overflow sets o_error=1 and o_cpu_hold stays 1.
  - No write is ever issued at an address >= 4*MEM_DEPTH.
- Timeout:
  - Active only in RECV with idx in 1..3.
  - The counter increments on every cycle without i_rx_valid and clears on each accepted byte.
  - Reaching TIMEOUT_CYCLES goes to ERROR with o_error=1; the partial word is discarded and not written.
  - There is no timeout with idx=0 (waiting for the start of a word is unbounded).
- i_start while o_busy=1 is ignored.
- o_inst_mem_wr_en is never high for more than one consecutive cycle.
- o_inst_mem_addr and o_inst_mem_data are registered and stable during the strobe. Their value is don't-care at other times but holds the last write.
- o_word_count saturates at MEM_DEPTH.

Test Plan:
- Reset then idle: outputs wr_en=0, busy=0, done=0, error=0, cpu_hold=1; rx bytes sent before i_start -> no write.
- Start, then bytes 0x13,0x00,0x00,0x20 and FF,FF,FF,FF -> two strobes: (addr 0, data 0x2000_0013) then (addr 4, data 0xFFFF_FFFF); done=1, cpu_hold=0, word_count=2.
- Back-to-back rx_valid on every cycle, including during WRITE, for 3 words + HALT -> 4 strobes at addrs 0,4,8,C; all bytes in correct lanes; no drops.
- MEM_DEPTH=4, five non-HALT words -> exactly 4 writes (addr 0..C), then error=1, cpu_hold=1, no 5th strobe.
- TIMEOUT_CYCLES=16, send 2 bytes then silence -> error=1 after 16 idle cycles, no write; new i_start clears error and accepts a fresh program from addr 0.
- Assert i_rst after 2 of 4 bytes -> immediate IDLE, cpu_hold=1, no write; i_start issued while busy -> ignored (word_count is not cleared).
